// File: rtl/ddr3_stream_pkg.sv
// ddr3_stream_pkg: shared constants and request bundle for the DDR3 stream writer
package ddr3_stream_pkg;

    localparam int WORD_BYTES       = 16;
    localparam int SAMPLES_PER_WORD = 4;

    typedef struct packed {
        logic [15:0]  mask;
        logic [31:0]  addr;
        logic [127:0] data;
        logic [15:0]  id;
    } mem_req_t;

endpackage

// File: rtl/ddr3_stream_pack.sv
// ddr3_stream_pack: packs 32-bit samples into a 128-bit word with byte mask, flushing on last
module ddr3_stream_pack
    import ddr3_stream_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic [31:0]  sample,
    input  logic         last,
    input  logic         take,
    output logic [127:0] word,
    output logic [15:0]  mask,
    output logic         done,
    output logic         empty
);

    logic [1:0]   cnt;
    logic [127:0] data_q;
    logic [15:0]  mask_q;
    logic         full_q;

    // merge the sample accepted this cycle so a completing word can be handed over on the same edge
    always_comb begin
        word = data_q;
        mask = mask_q;
        if (push) begin
            word[{cnt, 5'd0} +: 32] = sample;
            mask[{cnt, 2'd0} +: 4]  = 4'hF;
        end
        done = full_q | (push & (last | (cnt == 2'(SAMPLES_PER_WORD - 1))));
    end

    assign empty = (mask_q == '0);

    // partial word store; a take hands the word over and restarts with zeroed data
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            data_q <= '0;
            mask_q <= '0;
            full_q <= 1'b0;
        end else if (take) begin
            cnt    <= '0;
            data_q <= '0;
            mask_q <= '0;
            full_q <= 1'b0;
        end else begin
            cnt    <= cnt + 2'(push);
            data_q <= word;
            mask_q <= mask;
            full_q <= done;
        end
    end

endmodule

// File: rtl/ddr3_stream_writer.sv
// ddr3_stream_writer: streams packed sample words into a circular DDR3 region via ddr3_core mem_* port
module ddr3_stream_writer
    import ddr3_stream_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter logic [31:0] DEPTH_BYTES     = 32'h0010_0000,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    input  logic [31:0]  s_data_i,
    input  logic         s_last_i,
    output logic [15:0]  mem_wr_o,
    output logic         mem_rd_o,
    output logic [31:0]  mem_addr_o,
    output logic [127:0] mem_write_data_o,
    output logic [15:0]  mem_req_id_o,
    input  logic         mem_accept_i,
    input  logic         mem_ack_i,
    input  logic         mem_error_i,
    input  logic [15:0]  mem_resp_id_i,
    output logic [31:0]  wr_ptr_o,
    output logic         wrapped_o,
    output logic         err_o,
    output logic         idle_o
);

    localparam logic [31:0] LAST_ADDR = BASE_ADDR + DEPTH_BYTES - 32'(WORD_BYTES);
    localparam logic [3:0]  MAX_OUT   = 4'(MAX_OUTSTANDING);

    logic         push, take, fire, ack_ok, busy, issue;
    logic         pack_done, pack_empty, s_ready_q, wrapped_q, err_q;
    logic [127:0] pack_word, req_data;
    logic [15:0]  pack_mask, req_mask, req_id, exp_id;
    logic [31:0]  wr_ptr;
    logic [3:0]   outstanding;
    mem_req_t     req;

    ddr3_stream_pack u_pack (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .sample  (s_data_i),
        .last    (s_last_i),
        .take    (take),
        .word    (pack_word),
        .mask    (pack_mask),
        .done    (pack_done),
        .empty   (pack_empty)
    );

    assign push   = s_valid_i & s_ready_q;
    assign busy   = |req_mask;
    assign issue  = busy & (outstanding < MAX_OUT);
    assign fire   = issue & mem_accept_i;
    assign take   = pack_done & (!busy | fire);
    assign ack_ok = mem_ack_i & (outstanding != '0);
    assign req    = '{mask: req_mask, addr: wr_ptr, data: req_data, id: req_id};

    assign s_ready_o        = s_ready_q;
    assign mem_wr_o         = issue ? req.mask : '0;
    assign mem_rd_o         = 1'b0;
    assign mem_addr_o       = req.addr;
    assign mem_write_data_o = req.data;
    assign mem_req_id_o     = req.id;
    assign wr_ptr_o         = wr_ptr;
    assign wrapped_o        = wrapped_q;
    assign err_o            = err_q;
    assign idle_o           = pack_empty & !busy & (outstanding == '0);

    // request register: loads a finished word when empty or being accepted; ready drops while a finished word is stuck
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_mask  <= '0;
            req_data  <= '0;
            s_ready_q <= 1'b1;
        end else begin
            if (take) begin
                req_mask <= pack_mask;
                req_data <= pack_word;
            end else if (fire) begin
                req_mask <= '0;
            end
            s_ready_q <= !(pack_done & !take);
        end
    end

    // ring pointer, request/response IDs, outstanding count and sticky status flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= BASE_ADDR;
            req_id      <= 16'd1;
            exp_id      <= 16'd1;
            outstanding <= '0;
            wrapped_q   <= 1'b0;
            err_q       <= 1'b0;
        end else if (clear_i & idle_o) begin
            wr_ptr    <= BASE_ADDR;
            req_id    <= 16'd1;
            exp_id    <= 16'd1;
            wrapped_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (fire) begin
                wr_ptr    <= (wr_ptr == LAST_ADDR) ? BASE_ADDR : wr_ptr + 32'(WORD_BYTES);
                wrapped_q <= wrapped_q | (wr_ptr == LAST_ADDR);
                req_id    <= req_id + 16'd1;
            end
            if (ack_ok)
                exp_id <= exp_id + 16'd1;
            if (mem_ack_i & (!ack_ok | mem_error_i | (mem_resp_id_i != exp_id)))
                err_q <= 1'b1;
            outstanding <= outstanding + 4'(fire) - 4'(ack_ok);
        end
    end

endmodule

// File: tb/tb_ddr3_stream_writer.sv
// tb_ddr3_stream_writer: directed self-checking bench driving the mem_* port by hand
module tb_ddr3_stream_writer;
    import ddr3_stream_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic         clock = 1'b0, reset_n = 1'b0, clear_i = 1'b0;
    logic         s_valid_i = 1'b0, s_last_i = 1'b0;
    logic [31:0]  s_data_i = '0;
    logic         mem_accept_i = 1'b0, mem_ack_i = 1'b0, mem_error_i = 1'b0;
    logic [15:0]  mem_resp_id_i = '0;
    logic         s_ready_o, mem_rd_o, wrapped_o, err_o, idle_o;
    logic [15:0]  mem_wr_o, mem_req_id_o;
    logic [31:0]  mem_addr_o, wr_ptr_o;
    logic [127:0] mem_write_data_o;

    int checks = 0, errors = 0;
    mem_req_t log_q[$];

    always #5 clock = ~clock;

    ddr3_stream_writer #(
        .BASE_ADDR       (BASE),
        .DEPTH_BYTES     (32'd32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .clear_i          (clear_i),
        .s_valid_i        (s_valid_i),
        .s_ready_o        (s_ready_o),
        .s_data_i         (s_data_i),
        .s_last_i         (s_last_i),
        .mem_wr_o         (mem_wr_o),
        .mem_rd_o         (mem_rd_o),
        .mem_addr_o       (mem_addr_o),
        .mem_write_data_o (mem_write_data_o),
        .mem_req_id_o     (mem_req_id_o),
        .mem_accept_i     (mem_accept_i),
        .mem_ack_i        (mem_ack_i),
        .mem_error_i      (mem_error_i),
        .mem_resp_id_i    (mem_resp_id_i),
        .wr_ptr_o         (wr_ptr_o),
        .wrapped_o        (wrapped_o),
        .err_o            (err_o),
        .idle_o           (idle_o)
    );

    // record every request taken by the memory side
    always @(posedge clock)
        if (reset_n && mem_wr_o != 16'd0 && mem_accept_i)
            log_q.push_back('{mem_wr_o, mem_addr_o, mem_write_data_o, mem_req_id_o});

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        bit ok = 1'b0;
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_last_i  = l;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(posedge clock);
            ok = s_ready_o;
        end
        if (!ok) check("send_timeout", 0, 1);
        #1;
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic ack(input logic [15:0] id, input logic e);
        mem_ack_i     = 1'b1;
        mem_resp_id_i = id;
        mem_error_i   = e;
        @(negedge clock);
        mem_ack_i   = 1'b0;
        mem_error_i = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        @(negedge clock);
        clear_i = 1'b0;
    endtask

    task automatic chk_req(input string tag, input logic [15:0] m, input logic [31:0] a,
                           input logic [127:0] d, input logic [15:0] id);
        mem_req_t r;
        if (log_q.size() == 0) begin
            check({tag, "_missing"}, 0, 1);
        end else begin
            r = log_q.pop_front();
            check({tag, "_mask"}, r.mask, m);
            check({tag, "_addr"}, r.addr, a);
            check({tag, "_data"}, r.data, d);
            check({tag, "_id"}, r.id, id);
        end
    endtask

    initial begin
        int bad;
        logic [31:0]  h_addr;
        logic [127:0] h_data;
        logic [15:0]  h_id;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_ready", s_ready_o, 1);
        check("rst_wr", mem_wr_o, 0);
        check("rst_rd", mem_rd_o, 0);
        check("rst_addr", mem_addr_o, BASE);
        check("rst_data", mem_write_data_o, 0);
        check("rst_id", mem_req_id_o, 1);
        check("rst_ptr", wr_ptr_o, BASE);
        check("rst_wrapped", wrapped_o, 0);
        check("rst_err", err_o, 0);
        check("rst_idle", idle_o, 1);

        // full-rate stream, immediate accept, wrap on the second word
        mem_accept_i = 1'b1;
        for (int i = 0; i < 4; i++) send(32'(i), 1'b0);
        check("lat_full", mem_wr_o, 16'hFFFF);
        send(32'd4, 1'b0);
        check("wrap_pre", wrapped_o, 0);
        check("ptr_after1", wr_ptr_o, BASE + 32'd16);
        for (int i = 5; i < 8; i++) send(32'(i), 1'b0);
        repeat (3) @(negedge clock);
        check("t1_nreq", log_q.size(), 2);
        chk_req("t1_r1", 16'hFFFF, BASE, {32'd3, 32'd2, 32'd1, 32'd0}, 16'd1);
        chk_req("t1_r2", 16'hFFFF, BASE + 32'd16, {32'd7, 32'd6, 32'd5, 32'd4}, 16'd2);
        check("t1_wrapped", wrapped_o, 1);
        check("t1_ptr", wr_ptr_o, BASE);
        check("t1_busy", idle_o, 0);
        ack(16'd1, 1'b0);
        ack(16'd2, 1'b0);
        check("t1_idle", idle_o, 1);
        check("t1_err", err_o, 0);

        // accept held low: backpressure, stability, then outstanding limit
        mem_accept_i = 1'b0;
        for (int i = 0; i < 4; i++) send(32'h10 + 32'(i), 1'b0);
        check("t4_wr", mem_wr_o, 16'hFFFF);
        check("t4_addr", mem_addr_o, BASE);
        check("t4_id", mem_req_id_o, 3);
        for (int i = 4; i < 8; i++) send(32'h10 + 32'(i), 1'b0);
        check("t4_ready_low", s_ready_o, 0);
        s_valid_i = 1'b1;
        s_data_i  = 32'h18;
        s_last_i  = 1'b1;
        h_addr = mem_addr_o;
        h_data = mem_write_data_o;
        h_id   = mem_req_id_o;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (mem_addr_o !== h_addr || mem_write_data_o !== h_data || mem_req_id_o !== h_id ||
                mem_wr_o !== 16'hFFFF || s_ready_o !== 1'b0)
                bad++;
        end
        check("t4_stable", bad, 0);
        mem_accept_i = 1'b1;
        send(32'h18, 1'b1);
        check("t5_blocked", mem_wr_o, 0);
        check("t5_data", mem_write_data_o, 128'h18);
        check("t5_addr", mem_addr_o, BASE);
        check("t5_id", mem_req_id_o, 5);
        chk_req("t4_r3", 16'hFFFF, BASE, {32'h13, 32'h12, 32'h11, 32'h10}, 16'd3);
        chk_req("t4_r4", 16'hFFFF, BASE + 32'd16, {32'h17, 32'h16, 32'h15, 32'h14}, 16'd4);
        @(negedge clock);
        ack(16'd3, 1'b0);
        ack(16'd4, 1'b0);
        check("t5_same_edge_idle", idle_o, 0);
        check("t5_err", err_o, 0);
        chk_req("t5_r5", 16'h000F, BASE, 128'h18, 16'd5);
        ack(16'd5, 1'b0);
        check("t5_idle", idle_o, 1);
        check("t5_err2", err_o, 0);

        // partial word flushed by last
        for (int i = 0; i < 6; i++) send(32'h20 + 32'(i), i == 5);
        check("t2_lat", mem_wr_o, 16'h00FF);
        check("t2_id", mem_req_id_o, 7);
        repeat (2) @(negedge clock);
        chk_req("t2_r6", 16'hFFFF, BASE + 32'd16, {32'h23, 32'h22, 32'h21, 32'h20}, 16'd6);
        chk_req("t2_r7", 16'h00FF, BASE, {64'd0, 32'h25, 32'h24}, 16'd7);
        ack(16'd6, 1'b0);
        ack(16'd7, 1'b0);
        check("t2_idle", idle_o, 1);

        // error detection and clear
        for (int i = 0; i < 4; i++) send(32'h30 + 32'(i), 1'b0);
        repeat (2) @(negedge clock);
        chk_req("t6_r8", 16'hFFFF, BASE + 32'd16, {32'h33, 32'h32, 32'h31, 32'h30}, 16'd8);
        pulse_clear();
        check("t6_clear_ignored", mem_req_id_o, 9);
        ack(16'd9, 1'b0);
        check("t6_id_err", err_o, 1);
        check("t6_idle", idle_o, 1);
        repeat (3) @(negedge clock);
        check("t6_sticky", err_o, 1);
        pulse_clear();
        check("t6_clr_err", err_o, 0);
        check("t6_clr_ptr", wr_ptr_o, BASE);
        check("t6_clr_id", mem_req_id_o, 1);
        check("t6_clr_wrap", wrapped_o, 0);
        for (int i = 0; i < 4; i++) send(32'h40 + 32'(i), 1'b0);
        repeat (2) @(negedge clock);
        chk_req("t6_r1", 16'hFFFF, BASE, {32'h43, 32'h42, 32'h41, 32'h40}, 16'd1);
        ack(16'd1, 1'b1);
        check("t6_mem_err", err_o, 1);
        pulse_clear();
        check("t6_clr_err2", err_o, 0);
        ack(16'd1, 1'b0);
        check("t6_spurious_ack", err_o, 1);
        check("t6_spurious_idle", idle_o, 1);

        // asynchronous reset in the middle of a pending request
        mem_accept_i = 1'b0;
        for (int i = 0; i < 4; i++) send(32'h50 + 32'(i), 1'b0);
        check("rst_pending", mem_wr_o, 16'hFFFF);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("arst_wr", mem_wr_o, 0);
        check("arst_idle", idle_o, 1);
        check("arst_err", err_o, 0);
        check("arst_ready", s_ready_o, 1);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
